// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake with an ack timeout, branch resolution,
// forwarding tap and the MEM/WB pipeline register. All state changes on the falling clock edge.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clkEnable,
    input  logic        inBranch,
    input  logic        inZero,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemToReg,
    input  logic        inRegWrite,
    input  logic [9:0]  inBranchPC,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inData2,
    input  logic [4:0]  inWr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        PCSrc,
    output logic [9:0]  branchPC,
    output logic        stall,
    output logic [31:0] aluResult_MEMEXE,
    output logic [31:0] readData,
    output logic [31:0] aluResult,
    output logic [4:0]  wr,
    output logic        memToReg,
    output logic        regWrite,
    output logic        memError
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        timedOut;
    logic [31:0] capData;
    logic        memOp;
    logic        access;
    logic        misaligned;

    assign memOp      = inMemRead | inMemWrite;
    assign access     = memOp & (inAluResult[1:0] == 2'b00);
    assign misaligned = memOp & (inAluResult[1:0] != 2'b00);

    assign mem_req   = access & ((state == IDLE) || (state == WAIT));
    assign mem_we    = mem_req & inMemWrite;
    assign mem_addr  = inAluResult[11:2];
    assign mem_wdata = inData2;

    assign PCSrc            = inBranch & inZero;
    assign branchPC         = inBranchPC;
    assign aluResult_MEMEXE = inAluResult;

    // The access is released to WB in DONE; until then upstream must hold the instruction.
    assign stall = access & (state != DONE);

    // NOTE: sequential state is written with non-blocking assignments so every register
    // in this block sees the pre-edge values (e.g. the MEM/WB load reads the old timedOut).
    always_ff @(negedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            timedOut <= 1'b0;
            capData  <= '0;
            readData <= '0;
            aluResult <= '0;
            wr       <= '0;
            memToReg <= 1'b0;
            regWrite <= 1'b0;
            memError <= 1'b0;
        end else if (clkEnable) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (mem_ack) begin
                            state    <= DONE;
                            capData  <= mem_rdata;
                            timedOut <= 1'b0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (access && mem_ack) begin
                        state    <= DONE;
                        capData  <= mem_rdata;
                        timedOut <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        // Abandoned access: return zero data and flag the error in WB.
                        state    <= DONE;
                        capData  <= '0;
                        timedOut <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    timedOut <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (!stall) begin
                readData  <= inMemRead ? capData : 32'd0;
                aluResult <= inAluResult;
                wr        <= inWr;
                memToReg  <= inMemToReg;
                regWrite  <= inRegWrite & ~misaligned & ~timedOut;
                memError  <= misaligned | timedOut;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset, vector table, hand-written handshake/timeout/reset
// sequences and randomized instructions checked against a transaction-level model.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset, clkEnable;
    logic        inBranch, inZero, inMemRead, inMemWrite, inMemToReg, inRegWrite;
    logic [9:0]  inBranchPC;
    logic [31:0] inAluResult, inData2;
    logic [4:0]  inWr;
    logic        mem_req, mem_we, mem_ack;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        PCSrc, stall;
    logic [9:0]  branchPC;
    logic [31:0] aluResult_MEMEXE, readData, aluResult;
    logic [4:0]  wr;
    logic        memToReg, regWrite, memError;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .clkEnable(clkEnable),
        .inBranch(inBranch), .inZero(inZero), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .inBranchPC(inBranchPC),
        .inAluResult(inAluResult), .inData2(inData2), .inWr(inWr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .PCSrc(PCSrc), .branchPC(branchPC),
        .stall(stall), .aluResult_MEMEXE(aluResult_MEMEXE), .readData(readData),
        .aluResult(aluResult), .wr(wr), .memToReg(memToReg), .regWrite(regWrite),
        .memError(memError)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        branch, zero, memRead, memWrite, memToReg, regWrite;
        logic [9:0]  bpc;
        logic [31:0] alu, data2;
        logic [4:0]  wr;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        ePC, eStall, eRW, eErr;
        logic [31:0] eRd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Model state: last captured memory word and the expected MEM/WB contents.
    logic [31:0] modelCap;
    logic [31:0] eRd, eAlu;
    logic [4:0]  eWr;
    logic        eM2R, eRW, eErr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic instr_t mkInstr(input logic br, input logic zr, input logic rd, input logic wrt,
                                       input logic m2r, input logic rw, input logic [9:0] bpc,
                                       input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] w);
        instr_t i;
        i.branch = br; i.zero = zr; i.memRead = rd; i.memWrite = wrt; i.memToReg = m2r;
        i.regWrite = rw; i.bpc = bpc; i.alu = alu; i.data2 = d2; i.wr = w;
        return i;
    endfunction

    task automatic applyInstr(input instr_t i);
        inBranch = i.branch; inZero = i.zero; inMemRead = i.memRead; inMemWrite = i.memWrite;
        inMemToReg = i.memToReg; inRegWrite = i.regWrite; inBranchPC = i.bpc;
        inAluResult = i.alu; inData2 = i.data2; inWr = i.wr;
    endtask

    task automatic checkRegs(input string tag);
        check({tag, " readData"}, readData, eRd);
        check({tag, " aluResult"}, aluResult, eAlu);
        check({tag, " wr"}, 32'(wr), 32'(eWr));
        check({tag, " memToReg"}, 32'(memToReg), 32'(eM2R));
        check({tag, " regWrite"}, 32'(regWrite), 32'(eRW));
        check({tag, " memError"}, 32'(memError), 32'(eErr));
    endtask

    // Runs one instruction to completion. Expected stall length and WB contents come from the
    // handshake rules: ack after d wait cycles costs d+1 stall cycles, no ack within TO WAIT
    // cycles costs TO+1 and returns zero data with an error.
    task automatic runInstr(input string tag, input instr_t ins, input int ackDelay,
                            input logic [31:0] rdata, input int enProb,
                            output int stallSeen, output logic weSeen);
        logic isAcc, mis, tmo, en, done;
        int   expStall, k;
        isAcc    = (ins.memRead | ins.memWrite) && (ins.alu % 4 == 0);
        mis      = (ins.memRead | ins.memWrite) && (ins.alu % 4 != 0);
        tmo      = isAcc && (ackDelay > TO);
        expStall = !isAcc ? 0 : (tmo ? TO + 1 : ackDelay + 1);
        stallSeen = 0; weSeen = 1'b0; k = 0; done = 1'b0;
        applyInstr(ins);
        for (int it = 0; it < 80 && !done; it++) begin
            en = (enProb > 0 && $urandom_range(0, enProb - 1) == 0) ? 1'b0 : 1'b1;
            clkEnable = en;
            if (en && k < expStall) mem_ack = (k == ackDelay);
            else mem_ack = 1'($urandom);
            mem_rdata = (en && k == ackDelay) ? rdata : $urandom;
            #1;
            check({tag, " stall"}, 32'(stall), 32'(k < expStall));
            check({tag, " mem_req"}, 32'(mem_req), 32'(isAcc && k < expStall));
            check({tag, " mem_we"}, 32'(mem_we), 32'(isAcc && k < expStall && ins.memWrite));
            check({tag, " mem_addr"}, 32'(mem_addr), (ins.alu / 4) % 1024);
            check({tag, " PCSrc"}, 32'(PCSrc), 32'(ins.branch & ins.zero));
            if (en && stall) stallSeen++;
            if (mem_we) weSeen = 1'b1;
            @(negedge clock); #1;
            if (en && k == expStall) begin
                if (isAcc) modelCap = tmo ? 32'd0 : rdata;
                eRd  = ins.memRead ? modelCap : 32'd0;
                eAlu = ins.alu; eWr = ins.wr; eM2R = ins.memToReg;
                eRW  = ins.regWrite & !mis & !tmo;
                eErr = mis | tmo;
                checkRegs({tag, " wb"});
                done = 1'b1;
            end else begin
                check({tag, " hold aluResult"}, aluResult, eAlu);
                check({tag, " hold memError"}, 32'(memError), 32'(eErr));
                if (en) k++;
            end
        end
        if (!done) check({tag, " completion timeout"}, 32'd0, 32'd1);
    endtask

    vec_t   vecs[6];
    instr_t ins;
    int     sc;
    logic   we;

    initial begin
        // Vector table: single-cycle instructions, expected values read straight off the rules.
        vecs[0] = '{mkInstr(0,0,0,0,0,1,10'h000,32'h0000002A,32'h0,5'd5),  0,0,1,0,32'h0};
        vecs[1] = '{mkInstr(1,1,1,0,1,1,10'h03C,32'h00000013,32'h0,5'd9),  1,0,0,1,32'h0};
        vecs[2] = '{mkInstr(0,1,0,1,0,0,10'h155,32'h00000022,32'h55,5'd3), 0,0,0,1,32'h0};
        vecs[3] = '{mkInstr(1,0,0,0,1,1,10'h3FF,32'hFFFFFFFF,32'h0,5'd31), 0,0,1,0,32'h0};
        vecs[4] = '{mkInstr(0,1,1,1,0,1,10'h2AA,32'h00000001,32'h0,5'd1),  0,0,0,1,32'h0};
        vecs[5] = '{mkInstr(0,0,0,0,0,0,10'h000,32'h00000000,32'h0,5'd0),  0,0,0,0,32'h0};

        applyInstr(vecs[5].in);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        reset = 1'b1; clkEnable = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0; clkEnable = 1'b1;
        modelCap = 0; eRd = 0; eAlu = 0; eWr = 0; eM2R = 0; eRW = 0; eErr = 0;
        checkRegs("reset");
        check("reset stall", 32'(stall), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyInstr(vecs[i].in);
            mem_ack = 1'b0;
            #1;
            check($sformatf("vec%0d PCSrc", i), 32'(PCSrc), 32'(vecs[i].ePC));
            check($sformatf("vec%0d branchPC", i), 32'(branchPC), 32'(vecs[i].in.bpc));
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].eStall));
            check($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'd0);
            check($sformatf("vec%0d fwd", i), aluResult_MEMEXE, vecs[i].in.alu);
            @(negedge clock); #1;
            eRd = vecs[i].eRd; eAlu = vecs[i].in.alu; eWr = vecs[i].in.wr;
            eM2R = vecs[i].in.memToReg; eRW = vecs[i].eRW; eErr = vecs[i].eErr;
            checkRegs($sformatf("vec%0d", i));
        end

        // Load, ack after three wait cycles.
        ins = mkInstr(0,0,1,0,1,1,10'h0,32'h00000010,32'h0,5'd7);
        runInstr("load3", ins, 3, 32'hDEADBEEF, 0, sc, we);
        check("load3 mem_addr", 32'(mem_addr), 32'd4);
        check("load3 stall cycles", 32'(sc), 32'd4);
        check("load3 readData const", readData, 32'hDEADBEEF);
        check("load3 memError const", 32'(memError), 32'd0);

        // Store with immediate ack.
        ins = mkInstr(0,0,0,1,0,0,10'h0,32'h00000020,32'h12345678,5'd0);
        runInstr("store0", ins, 0, 32'hCAFEF00D, 0, sc, we);
        check("store0 mem_we seen", 32'(we), 32'd1);
        check("store0 mem_addr", 32'(mem_addr), 32'd8);
        check("store0 mem_wdata", mem_wdata, 32'h12345678);
        check("store0 stall cycles", 32'(sc), 32'd1);

        // Load that is never acknowledged.
        ins = mkInstr(0,0,1,0,1,1,10'h0,32'h00000040,32'h0,5'd12);
        runInstr("timeout", ins, 99, 32'h0, 0, sc, we);
        check("timeout stall cycles", 32'(sc), 32'd16);
        check("timeout readData const", readData, 32'd0);
        check("timeout regWrite const", 32'(regWrite), 32'd0);
        check("timeout memError const", 32'(memError), 32'd1);

        // Pipeline freeze: registers hold, forwarding follows the input.
        clkEnable = 1'b0;
        inAluResult = 32'hA5A5A5A4; inMemRead = 1'b0; inMemWrite = 1'b0; inWr = 5'd30;
        repeat (3) @(negedge clock);
        #1;
        check("freeze fwd", aluResult_MEMEXE, 32'hA5A5A5A4);
        checkRegs("freeze");

        // Reset in the second WAIT cycle abandons the access.
        ins = mkInstr(0,0,1,0,1,1,10'h0,32'h00000010,32'h0,5'd4);
        applyInstr(ins);
        clkEnable = 1'b1; mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        check("rstwait mem_req before", 32'(mem_req), 32'd1);
        @(negedge clock); #1;
        reset = 1'b0;
        modelCap = 0; eRd = 0; eAlu = 0; eWr = 0; eM2R = 0; eRW = 0; eErr = 0;
        checkRegs("rstwait");
        applyInstr(vecs[5].in);
        #1;
        check("rstwait mem_req after", 32'(mem_req), 32'd0);
        ins = mkInstr(0,0,1,0,1,1,10'h0,32'h00000010,32'h0,5'd4);
        runInstr("rstwait relaunch", ins, 2, 32'h0BADF00D, 0, sc, we);
        check("rstwait relaunch stall cycles", 32'(sc), 32'd3);

        // Randomized instruction stream with random freeze cycles.
        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            ins.branch = 1'($urandom); ins.zero = 1'($urandom);
            ins.memToReg = 1'($urandom); ins.regWrite = 1'($urandom);
            ins.bpc = 10'($urandom); ins.data2 = $urandom; ins.wr = 5'($urandom);
            ins.alu = $urandom & 32'hFFFFFFFC;
            ins.memRead = (kind == 1); ins.memWrite = (kind == 2);
            if (kind == 3) begin
                ins.memRead = 1'($urandom); ins.memWrite = !ins.memRead;
                ins.alu = ins.alu | 32'($urandom_range(1, 3));
            end
            runInstr($sformatf("rand%0d", n), ins, $urandom_range(0, 18), $urandom, 6, sc, we);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: WAIT-state cycles without mem_ack before an access is abandoned.
REQ-002 clock  in  1  stage clock; all state updates on negedge clock, matching upstream EX/MEM register.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 clkEnable  in  1  global pipeline enable; low freezes all state.
REQ-005 inBranch, inZero  in  1 each  branch flag and ALU zero from EX/MEM register.
REQ-006 inMemRead, inMemWrite, inMemToReg, inRegWrite  in  1 each  control from EX/MEM register.
REQ-007 inBranchPC  in  10  branch target; inAluResult  in  32  address/ALU value; inData2  in  32  store data; inWr  in  5  destination register.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  10 (= inAluResult[11:2]); mem_wdata  out  32 (= inData2); mem_ack  in  1; mem_rdata  in  32  data-memory handshake.
REQ-009 PCSrc  out  1; branchPC  out  10  branch decision/target to fetch and flush logic.
REQ-010 stall  out  1  freezes upstream stages while a memory access is outstanding.
REQ-011 aluResult_MEMEXE  out  32  forwarding value (= inAluResult, combinational).
REQ-012 readData, aluResult  out  32 each; wr  out  5; memToReg, regWrite, memError  out  1 each  registered MEM/WB outputs.

Function
REQ-013 PCSrc SHALL equal inBranch & inZero combinationally; branchPC SHALL equal inBranchPC.
REQ-014 access SHALL equal (inMemRead | inMemWrite) & (inAluResult[1:0] == 0); misaligned = (inMemRead | inMemWrite) & (inAluResult[1:0] != 0).
REQ-015 FSM states SHALL be IDLE, WAIT, DONE; 4-bit wait counter cnt.
REQ-016 IDLE: access & mem_ack -> DONE; access & !mem_ack -> WAIT, cnt=0; else stay.
REQ-017 WAIT: mem_ack -> DONE; cnt == TIMEOUT-1 -> DONE with timeout flag set; else cnt+1.
REQ-018 DONE -> IDLE unconditionally.
REQ-019 mem_req SHALL equal access & (state IDLE or WAIT); mem_we SHALL equal mem_req & inMemWrite.
REQ-020 stall SHALL equal access & (state != DONE).
REQ-021 mem_rdata SHALL be captured on the edge where mem_ack is sampled in IDLE/WAIT; on timeout the captured value SHALL be 0.
REQ-022 MEM/WB register SHALL load on an enabled edge with stall=0: readData = captured data if inMemRead else 0; aluResult, wr, memToReg pass through.
REQ-023 regWrite SHALL load inRegWrite & !misaligned & !timeout.
REQ-024 memError SHALL load misaligned | timeout, for one stage slot.
REQ-025 Non-memory and misaligned instructions SHALL pass with zero added latency (stall=0, no mem_req).
REQ-026 Aligned accesses SHALL add (ack wait cycles + 1) stall cycles; zero-wait ack gives exactly 1 stall cycle.
REQ-027 clkEnable=0 SHALL hold state, cnt, captured data and MEM/WB register; combinational outputs still follow inputs.
REQ-028 mem_ack outside IDLE/WAIT-with-access SHALL be ignored.

Reset
REQ-029 On reset edge (independent of clkEnable): state=IDLE, cnt=0, timeout=0, captured data=0, readData=0, aluResult=0, wr=0, memToReg=0, regWrite=0, memError=0.
REQ-030 Reset during WAIT SHALL abandon the access; mem_req SHALL be low from the cycle after reset unless a new access is presented.

Verification
REQ-031 ALU op, inAluResult=0x0000002A, inWr=5, inRegWrite=1 -> next edge aluResult=0x2A, wr=5, regWrite=1, stall never high.
REQ-032 Load inAluResult=0x10, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=4, stall high 4 cycles, readData=0xDEADBEEF, memError=0.
REQ-033 Store inAluResult=0x20, inData2=0x12345678, immediate ack -> mem_we=1, mem_addr=8, mem_wdata=0x12345678, stall exactly 1 cycle.
REQ-034 Load with no ack, TIMEOUT=15 -> after 15 WAIT cycles DONE, readData=0, regWrite=0, memError=1.
REQ-035 Load inAluResult=0x13 -> no mem_req, stall=0, regWrite=0, memError=1; inBranch=1, inZero=1, inBranchPC=0x3C -> PCSrc=1, branchPC=0x3C.
REQ-036 Reset asserted in WAIT cycle 2 -> all registered outputs 0, state IDLE, mem_req low next cycle.
